// File: rtl/c17_bist_pkg.sv
// Shared types, widths and step functions for the c17 BIST controller.
// Optional macro C17_BIST_RSP_PIPE_EN inserts one response register ahead of the MISR.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } c17_bist_state_e;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;

  // x^5 + x^3 + 1 in Fibonacci form: feedback = s[4] ^ s[2]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

`ifdef C17_BIST_RSP_PIPE_EN
  localparam int RSP_STAGES = 1;
`else
  localparam int RSP_STAGES = 0;
`endif

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                  input logic [1:0]        r);
    return ({m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}}))
           ^ {{(MISR_W-2){1'b0}}, r};
  endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// Signature register with clear/enable; C17_BIST_RSP_PIPE_EN adds a response flop
// whose valid trails the pattern enable by one cycle.
module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic              CK,
  input  logic              RN,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [1:0]        i_rsp,
  output logic [MISR_W-1:0] o_sig,
  output logic [MISR_W-1:0] o_sig_nxt
);

  logic [MISR_W-1:0] r_sig;
  logic [1:0]        w_rsp;
  logic              w_en;

`ifdef C17_BIST_RSP_PIPE_EN
  logic [1:0] r_rsp;
  logic       r_vld;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_rsp <= '0;
      r_vld <= 1'b0;
    end else begin
      r_rsp <= i_rsp;
      r_vld <= i_en & ~i_clr;
    end
  end

  assign w_rsp = r_rsp;
  assign w_en  = r_vld;
`else
  assign w_rsp = i_rsp;
  assign w_en  = i_en;
`endif

  assign o_sig_nxt = misr_next(r_sig, w_rsp);
  assign o_sig     = r_sig;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN)        r_sig <= '0;
    else if (i_clr) r_sig <= '0;
    else if (w_en)  r_sig <= o_sig_nxt;
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 core: LFSR pattern source, MISR compactor, start/busy/done FSM.
// Macro C17_BIST_RSP_PIPE_EN registers rsp_i and adds one drain cycle to RUN.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter logic [7:0]        N_PAT      = 8'd31,
  parameter logic [LFSR_W-1:0] SEED       = 5'h01,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 8'h00
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] pat_o,
  input  logic [1:0]        rsp_i,
  output logic [MISR_W-1:0] signature,
  output logic              pass
);

  // Last RUN count value; with the response pipe one drain cycle follows the last pattern.
  localparam logic [8:0] LAST_CNT = 9'(N_PAT) - 9'd1 + 9'(RSP_STAGES);

  c17_bist_state_e   r_state, w_state_nxt;
  logic [7:0]        r_cnt;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_pass;
  logic              w_start, w_last, w_pat_en;
  logic [MISR_W-1:0] w_sig_nxt;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && ({1'b0, r_cnt} == LAST_CNT);
  assign w_pat_en = (r_state == S_RUN) && ({1'b0, r_cnt} < 9'(N_PAT));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // pass is taken from the MISR's next value so it is already valid during the done pulse.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_lfsr <= SEED;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_lfsr <= SEED;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_lfsr <= lfsr_next(r_lfsr);
      r_cnt  <= r_cnt + 8'd1;
      if (w_last) r_pass <= (w_sig_nxt == GOLDEN_SIG);
    end
  end

  c17_bist_misr u_misr (
    .CK        (CK),
    .RN        (RN),
    .i_clr     (w_start),
    .i_en      (w_pat_en),
    .i_rsp     (rsp_i),
    .o_sig     (signature),
    .o_sig_nxt (w_sig_nxt)
  );

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign pat_o = r_lfsr;
  assign pass  = r_pass;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench: three controller instances (N_PAT 4 / 9 / 31); the last one drives a c17 model.
module tb_c17_bist_ctrl;

`ifdef C17_BIST_RSP_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         len;
  } exp_t;

  logic            CK = 1'b0;
  logic            RN = 1'b1;
  logic [2:0]      st = '0;
  logic [2:0]      bsy, dn, ps;
  logic [2:0][4:0] pat;
  logic [2:0][7:0] sig;
  logic [1:0]      rsp_c;

  int   checks = 0;
  int   errors = 0;
  exp_t q[3][$];
  int   run_cnt[3];
  logic prev_dn[3];

  localparam int NP[3] = '{4, 9, 31};
  localparam logic [4:0] PATS[9] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12,
                                     5'h05, 5'h0B, 5'h16, 5'h0C};

  always #5 CK = ~CK;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [7:0] c17_sig(input int n);
    logic [4:0] s;
    logic [7:0] m;
    s = 5'h01;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, c17(s)};
      s = {s[3:0], s[4] ^ s[2]};
    end
    return m;
  endfunction

  assign rsp_c = c17(pat[2]);

  c17_bist_ctrl #(.N_PAT(8'd4), .SEED(5'h01), .GOLDEN_SIG(8'h11)) u_a (
    .CK(CK), .RN(RN), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
    .pat_o(pat[0]), .rsp_i(2'b11), .signature(sig[0]), .pass(ps[0]));

  c17_bist_ctrl #(.N_PAT(8'd9), .SEED(5'h01), .GOLDEN_SIG(8'h00)) u_b (
    .CK(CK), .RN(RN), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
    .pat_o(pat[1]), .rsp_i(2'b01), .signature(sig[1]), .pass(ps[1]));

  c17_bist_ctrl #(.N_PAT(8'd31), .SEED(5'h01), .GOLDEN_SIG(8'h00)) u_c (
    .CK(CK), .RN(RN), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
    .pat_o(pat[2]), .rsp_i(rsp_c), .signature(sig[2]), .pass(ps[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse, also checks pattern order and pulse width.
  always @(negedge CK) begin
    for (int d = 0; d < 3; d++) begin
      if (!RN) begin
        run_cnt[d] = 0;
        prev_dn[d] = 1'b0;
      end else begin
        if (prev_dn[d]) chk($sformatf("done_width[%0d]", d), dn[d], 0);
        if (bsy[d] && d < 2 && run_cnt[d] < NP[d])
          chk($sformatf("pat[%0d][%0d]", d, run_cnt[d]), pat[d], PATS[run_cnt[d]]);
        if (bsy[d]) run_cnt[d]++;
        if (dn[d]) begin
          if (q[d].size() == 0) begin
            chk($sformatf("unexpected_done[%0d]", d), 1, 0);
          end else begin
            exp_t e;
            e = q[d].pop_front();
            chk($sformatf("signature[%0d]", d), sig[d], e.sig);
            chk($sformatf("pass[%0d]", d), ps[d], e.pass);
            chk($sformatf("busy_len[%0d]", d), run_cnt[d], e.len);
          end
          run_cnt[d] = 0;
        end
        prev_dn[d] = dn[d];
      end
    end
  end

  task automatic push(input int d, input logic [7:0] s, input logic p);
    exp_t e;
    e.sig  = s;
    e.pass = p;
    e.len  = NP[d] + PIPE;
    q[d].push_back(e);
  endtask

  task automatic start_pulse(input int d);
    @(negedge CK);
    st[d] = 1'b1;
    @(negedge CK);
    st[d] = 1'b0;
    chk($sformatf("start_to_busy[%0d]", d), bsy[d], 1);
  endtask

  task automatic wait_done(input int d, input int lim);
    logic got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge CK);
      if (dn[d]) got = 1'b1;
    end
    if (!got) chk($sformatf("done_timeout[%0d]", d), 0, 1);
  endtask

  task automatic reset_vals(input int d, input string tag);
    chk($sformatf("%s_busy[%0d]", tag, d), bsy[d], 0);
    chk($sformatf("%s_done[%0d]", tag, d), dn[d], 0);
    chk($sformatf("%s_pat[%0d]", tag, d), pat[d], 5'h01);
    chk($sformatf("%s_sig[%0d]", tag, d), sig[d], 8'h00);
    chk($sformatf("%s_pass[%0d]", tag, d), ps[d], 0);
  endtask

  initial begin
    logic [7:0] sig_c;
    sig_c = c17_sig(31);

    #2 RN = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) reset_vals(d, "reset");
    repeat (2) @(negedge CK);
    RN = 1'b1;

    // N_PAT=4 with rsp 11: signature 11 matches golden
    push(0, 8'h11, 1'b1);
    start_pulse(0);
    wait_done(0, 20);
    @(negedge CK);

    // N_PAT=9 with rsp 01: wraps through MISR feedback
    push(1, 8'hE2, 1'b0);
    start_pulse(1);
    wait_done(1, 30);
    @(negedge CK);

    // start held into RUN and re-pulsed during DONE must not restart
    push(0, 8'h11, 1'b1);
    @(negedge CK);
    st[0] = 1'b1;
    @(negedge CK);
    chk("restart_busy", bsy[0], 1);
    @(negedge CK);
    st[0] = 1'b0;
    wait_done(0, 20);
    st[0] = 1'b1;
    @(negedge CK);
    st[0] = 1'b0;
    chk("no_restart_from_done", bsy[0], 0);
    repeat (8) @(negedge CK);

    // full 31-pattern session against the c17 model
    push(2, sig_c, sig_c == 8'h00);
    start_pulse(2);
    wait_done(2, 60);
    @(negedge CK);

    // interrupted session: discarded, no done expected
    start_pulse(2);
    repeat (9) @(negedge CK);
    #2 RN = 1'b0;
    #1 reset_vals(2, "midrun");
    @(negedge CK);
    @(negedge CK);
    RN = 1'b1;

    push(2, sig_c, sig_c == 8'h00);
    start_pulse(2);
    wait_done(2, 60);
    repeat (3) @(negedge CK);

    for (int d = 0; d < 3; d++)
      chk($sformatf("pending_expect[%0d]", d), q[d].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
